// File: rtl/robo_sequencer_if.sv
// Request/action/status bundle between the robot FSM side and the mission sequencer.
interface robo_sequencer_if #(
  parameter int STEP_W = 16
);
  logic              start;
  logic              stop;
  logic              req_avancar;
  logic              req_girar;
  logic              req_remover;
  logic              avancar;
  logic              girar;
  logic              remover;
  logic              sensor_valid;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              trapped;
  logic              conflict;
  logic [STEP_W-1:0] step_count;
  logic [STEP_W-1:0] remove_count;

  modport master (
    output start, stop, req_avancar, req_girar, req_remover,
    input  avancar, girar, remover, sensor_valid, busy, done,
    input  timeout, trapped, conflict, step_count, remove_count
  );

  modport slave (
    input  start, stop, req_avancar, req_girar, req_remover,
    output avancar, girar, remover, sensor_valid, busy, done,
    output timeout, trapped, conflict, step_count, remove_count
  );
endinterface

// File: rtl/robo_sequencer.sv
// Mission sequencer: one action pulse the cycle after a request is sampled, then a settle
// window of SETTLE_CYCLES during which requests are not sampled (sensor_valid low).
module robo_sequencer #(
  parameter int STEP_W        = 16,
  parameter int MAX_STEPS     = 1000,
  parameter int SETTLE_CYCLES = 2,
  parameter int TRAP_TURNS    = 4
) (
  input  logic            clock,
  input  logic            reset,
  robo_sequencer_if.slave bus
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TRAP_TURNS + 1);
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]     TRAP_N      = TW'(TRAP_TURNS);
  localparam logic [STEP_W-1:0] MAX_N       = STEP_W'(MAX_STEPS);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_SETTLE, S_FINISH} state_t;
  typedef enum logic [1:0] {ACT_AVANCAR, ACT_GIRAR, ACT_REMOVER} act_t;

  state_t            state, state_nxt;
  act_t              act;
  logic [SW-1:0]     settle_cnt;
  logic [TW-1:0]     turn_streak;
  logic [STEP_W-1:0] step_count, remove_count;
  logic              timeout, trapped, conflict, stop_pending;

  logic any_req, multi_req, settle_end, trap_hit, budget_hit;

  assign any_req    = bus.req_avancar | bus.req_girar | bus.req_remover;
  assign multi_req  = (bus.req_remover & bus.req_girar) | (bus.req_remover & bus.req_avancar) |
                      (bus.req_girar & bus.req_avancar);
  assign settle_end = (state == S_SETTLE) && (settle_cnt == '0);
  assign trap_hit   = (turn_streak == TRAP_N);
  assign budget_hit = (step_count == MAX_N);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.stop)     state_nxt = S_FINISH;
        else if (any_req) state_nxt = S_ISSUE;
      end
      S_ISSUE:  state_nxt = S_SETTLE;
      S_SETTLE: begin
        // A stop arriving in the last settle cycle still ends the mission here.
        if (settle_end) begin
          if (trap_hit || budget_hit || stop_pending || bus.stop) state_nxt = S_FINISH;
          else                                                    state_nxt = S_WAIT;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      act          <= ACT_AVANCAR;
      settle_cnt   <= '0;
      turn_streak  <= '0;
      step_count   <= '0;
      remove_count <= '0;
      timeout      <= 1'b0;
      trapped      <= 1'b0;
      conflict     <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            turn_streak  <= '0;
            step_count   <= '0;
            remove_count <= '0;
            timeout      <= 1'b0;
            trapped      <= 1'b0;
            conflict     <= 1'b0;
            stop_pending <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!bus.stop && any_req) begin
            if (bus.req_remover)    act <= ACT_REMOVER;
            else if (bus.req_girar) act <= ACT_GIRAR;
            else                    act <= ACT_AVANCAR;
            if (multi_req) conflict <= 1'b1;
          end
        end
        S_ISSUE: begin
          step_count <= step_count + STEP_W'(1);
          if (act == ACT_REMOVER) remove_count <= remove_count + STEP_W'(1);
          if (act == ACT_GIRAR)   turn_streak  <= turn_streak + TW'(1);
          if (act == ACT_AVANCAR) turn_streak  <= '0;
          settle_cnt <= SETTLE_LOAD;
          if (bus.stop) stop_pending <= 1'b1;
        end
        S_SETTLE: begin
          if (bus.stop) stop_pending <= 1'b1;
          if (!settle_end)     settle_cnt <= settle_cnt - SW'(1);
          else if (trap_hit)   trapped    <= 1'b1;
          else if (budget_hit) timeout    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.avancar      = (state == S_ISSUE) && (act == ACT_AVANCAR);
  assign bus.girar        = (state == S_ISSUE) && (act == ACT_GIRAR);
  assign bus.remover      = (state == S_ISSUE) && (act == ACT_REMOVER);
  assign bus.sensor_valid = (state == S_WAIT);
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = (state == S_FINISH);
  assign bus.timeout      = timeout;
  assign bus.trapped      = trapped;
  assign bus.conflict     = conflict;
  assign bus.step_count   = step_count;
  assign bus.remove_count = remove_count;

endmodule

// File: tb/tb_robo_sequencer.sv
// Directed bench for robo_sequencer: a cycle-timeline model checked every cycle, plus
// hand-computed end-of-mission values pinned per mission.
module tb_robo_sequencer;
  localparam int S      = 2;
  localparam int MAXS   = 8;
  localparam int TRAP   = 4;
  localparam int NEVER  = 32'h7fffffff;
  localparam int NMISS  = 9;

  logic clock = 1'b0;
  logic reset = 1'b1;

  robo_sequencer_if #(.STEP_W(16)) bus();

  robo_sequencer #(
    .STEP_W(16), .MAX_STEPS(MAXS), .SETTLE_CYCLES(S), .TRAP_TURNS(TRAP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial forever #5 clock = ~clock;

  // Hand-computed values at each done pulse, in mission order.
  int lit_steps [NMISS] = '{3, 1, 4, 5, 7, 8, 0, 1, 2};
  int lit_rm    [NMISS] = '{0, 1, 0, 1, 0, 0, 0, 0, 1};
  int lit_tmo   [NMISS] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
  int lit_trap  [NMISS] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
  int lit_conf  [NMISS] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};

  // Timeline model: cycle numbers of the next pulse, next request window and done pulse.
  int cyc = 0;
  bit m_valid = 0, m_rst = 0, m_busy = 0;
  int m_pulse = -1, m_win = NEVER, m_done = -1, m_act = 0;
  int m_steps = 0, m_rm = 0, m_streak = 0;
  bit m_tmo = 0, m_trap = 0, m_conf = 0, m_stopp = 0;

  initial forever begin
    int cur, nreq;
    bit fin;
    @(posedge clock);
    cur = cyc;
    fin = 0;
    if (reset) begin
      m_valid = 1; m_rst = 1; m_busy = 0;
      m_pulse = -1; m_win = NEVER; m_done = -1;
      m_steps = 0; m_rm = 0; m_streak = 0;
      m_tmo = 0; m_trap = 0; m_conf = 0; m_stopp = 0;
    end else begin
      m_rst = 0;
      nreq = int'(bus.req_avancar) + int'(bus.req_girar) + int'(bus.req_remover);
      if (!m_busy) begin
        if (bus.start) begin
          m_busy = 1; m_win = cur + 1; m_pulse = -1; m_done = -1;
          m_steps = 0; m_rm = 0; m_streak = 0;
          m_tmo = 0; m_trap = 0; m_conf = 0; m_stopp = 0;
        end
      end else if (cur == m_done) begin
        m_busy = 0; m_win = NEVER;
      end else if (cur >= m_win) begin
        if (bus.stop) begin
          m_done = cur + 1; m_win = NEVER;
        end else if (nreq > 0) begin
          m_act   = bus.req_remover ? 2 : (bus.req_girar ? 1 : 0);
          if (nreq >= 2) m_conf = 1;
          m_pulse = cur + 1;
          m_win   = cur + 2 + S;
        end
      end else begin
        if (bus.stop) m_stopp = 1;
        if (cur == m_pulse) begin
          m_steps++;
          if (m_act == 2) m_rm++;
          if (m_act == 1) m_streak++;
          if (m_act == 0) m_streak = 0;
        end
        if (cur == m_win - 1) begin
          if (m_streak == TRAP)      begin m_trap = 1; fin = 1; end
          else if (m_steps == MAXS)  begin m_tmo = 1;  fin = 1; end
          else if (m_stopp)          fin = 1;
          if (fin) begin m_done = cur + 1; m_win = NEVER; end
        end
      end
    end
    cyc = cur + 1;
  end

  int n_chk = 0, n_fail = 0;
  int tmo_cnt = 0, tmo_seen = 0;
  int mi = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    logic [8:0] a_flags, e_flags;
    bit e_done;
    @(negedge clock);
    if (tmo_cnt != tmo_seen) begin
      n_chk++; n_fail++;
      $display("FAIL wait_bound: %0d waits expired, expected 0", tmo_cnt);
      tmo_seen = tmo_cnt;
    end
    if (m_valid) begin
      e_done  = (cyc == m_done);
      a_flags = {bus.avancar, bus.girar, bus.remover, bus.sensor_valid, bus.busy,
                 bus.done, bus.timeout, bus.trapped, bus.conflict};
      e_flags = {cyc == m_pulse && m_act == 0, cyc == m_pulse && m_act == 1,
                 cyc == m_pulse && m_act == 2, m_busy && cyc >= m_win, m_busy,
                 e_done, m_tmo, m_trap, m_conf};
      chk("outputs", int'(a_flags), int'(e_flags));
      chk("step_count", int'(bus.step_count), m_steps);
      chk("remove_count", int'(bus.remove_count), m_rm);
      if (m_rst) begin
        chk("reset_outputs", int'(a_flags), 0);
        chk("reset_step_count", int'(bus.step_count), 0);
      end
      if (e_done) begin
        if (mi < NMISS) begin
          chk("mission_steps", int'(bus.step_count), lit_steps[mi]);
          chk("mission_removes", int'(bus.remove_count), lit_rm[mi]);
          chk("mission_timeout", int'(bus.timeout), lit_tmo[mi]);
          chk("mission_trapped", int'(bus.trapped), lit_trap[mi]);
          chk("mission_conflict", int'(bus.conflict), lit_conf[mi]);
        end else begin
          n_chk++; n_fail++;
          $display("FAIL extra_done: mission %0d, expected at most %0d", mi, NMISS);
        end
        mi++;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_window();
    int n = 0;
    while (!bus.sensor_valid && n < 50) begin tick(1); n++; end
    if (!bus.sensor_valid) tmo_cnt++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 50) begin tick(1); n++; end
    if (bus.busy) tmo_cnt++;
    tick(1);
  endtask

  task automatic go();
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
  endtask

  task automatic request(bit a, bit g, bit r);
    wait_window();
    bus.req_avancar = a; bus.req_girar = g; bus.req_remover = r;
    tick(1);
    bus.req_avancar = 1'b0; bus.req_girar = 1'b0; bus.req_remover = 1'b0;
  endtask

  task automatic stop_in_window();
    wait_window();
    bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
    wait_idle();
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.req_avancar = 1'b0; bus.req_girar = 1'b0; bus.req_remover = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Back-to-back avancar: windows every S+2 cycles, stop at the 4th window.
    go();
    bus.req_avancar = 1'b1;
    tick(3 * (S + 2));
    bus.req_avancar = 1'b0;
    bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
    wait_idle();

    // All three requests at once.
    go(); request(1, 1, 1); stop_in_window();

    // Four turns trap the robot.
    go(); repeat (4) request(0, 1, 0); wait_idle();

    // remover keeps the streak.
    go(); request(0, 1, 0); request(0, 1, 0); request(0, 0, 1);
    request(0, 1, 0); request(0, 1, 0); wait_idle();

    // avancar breaks the streak.
    go(); repeat (3) request(0, 1, 0); request(1, 0, 0);
    repeat (3) request(0, 1, 0); stop_in_window();

    // Step budget, then a held request that must never issue.
    go();
    repeat (4) begin request(1, 0, 0); request(0, 1, 0); end
    bus.req_avancar = 1'b1; tick(8); bus.req_avancar = 1'b0;
    wait_idle();

    // stop in WAIT beats a simultaneous request.
    go(); wait_window();
    bus.stop = 1'b1; bus.req_girar = 1'b1; tick(1);
    bus.stop = 1'b0; bus.req_girar = 1'b0;
    wait_idle();

    // stop (and an ignored start) during the girar pulse.
    go(); request(0, 1, 0);
    bus.stop = 1'b1; bus.start = 1'b1; tick(1);
    bus.stop = 1'b0; bus.start = 1'b0;
    wait_idle();

    // Reset in the ISSUE cycle, then a clean mission.
    go(); request(1, 0, 0);
    reset = 1'b1; tick(1); reset = 1'b0; tick(2);
    go(); request(0, 0, 1); request(1, 0, 0); stop_in_window();

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/robo_sequencer.md
Name: robo_sequencer

Overview:
- Mission controller between the cleaning-robot FSM and the map/sensor memory.
- Accepts the robot's action requests (avancar/girar/remover) one at a time and forwards exactly one single-cycle action pulse per step to the memory.
- After each pulse, holds a settle window so the memory's head/left/under/barrier outputs are stable before the robot may request again.
- Counts steps and removals, detects a trapped robot (endless turning), enforces a step budget, and reports mission completion.

Parameters:
- STEP_W, 16, width of step_count and remove_count.
- MAX_STEPS, 1000, step budget; when reached the mission ends with timeout (must be >=1, < 2^STEP_W).
- SETTLE_CYCLES, 2, cycles between an action pulse and the next request window (must be >=1).
- TRAP_TURNS, 4, number of consecutive girar steps without an avancar that declares the robot trapped (must be >=1).

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high; one clock; no other reset.
- start, input, 1, begins a mission when sampled high in IDLE; ignored otherwise.
- stop, input, 1, requests mission abort.
- req_avancar, input, 1, robot requests advance.
- req_girar, input, 1, robot requests turn.
- req_remover, input, 1, robot requests dirt/barrier removal.
- avancar, output, 1, advance pulse to memory.
- girar, output, 1, turn pulse to memory.
- remover, output, 1, remove pulse to memory.
- sensor_valid, output, 1, high only in WAIT: sensors are stable and a request will be sampled.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when a mission ends.
- timeout, output, 1, sticky: mission ended on MAX_STEPS.
- trapped, output, 1, sticky: mission ended on TRAP_TURNS.
- conflict, output, 1, sticky: more than one request was seen high in the same WAIT cycle.
- step_count, output, STEP_W, actions issued this mission.
- remove_count, output, STEP_W, remover actions issued this mission.

Behaviour:
- Reset: state=IDLE. All outputs are 0, including counters, flags and the internal turn streak. Reset takes effect on the same edge from any state. A pulse in flight is dropped: action outputs are 0 in the cycle after the reset edge.
- States: IDLE, WAIT, ISSUE, SETTLE, FINISH.
- IDLE:
  - Action outputs are 0.
  - start=1 -> WAIT. On the same edge, step_count, remove_count, turn_streak, timeout, trapped, conflict and stop_pending are cleared.
  - stop is ignored in IDLE.
- WAIT:
  - sensor_valid=1.
  - stop=1 -> FINISH. stop has priority over any request sampled in the same cycle; that request is discarded.
  - Otherwise, if any request is high, latch one action and go to ISSUE. Priority is remover > girar > avancar. If 2 or more requests are high, set conflict=1.
  - No request: stay in WAIT indefinitely.
- ISSUE (exactly 1 cycle):
  - Exactly the latched action output is 1; the other two are 0.
  - On exit: step_count+1; remove_count+1 if remover.
  - turn_streak: +1 on girar, cleared on avancar, unchanged on remover.
  - Load settle counter, then -> SETTLE.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles; action outputs are 0.
  - stop=1 seen during ISSUE or SETTLE sets stop_pending. The in-flight action always completes.
  - At the end of SETTLE, the first matching condition applies:
    1. turn_streak==TRAP_TURNS -> trapped=1, FINISH.
    2. step_count==MAX_STEPS -> timeout=1, FINISH.
    3. stop_pending -> FINISH.
    4. Otherwise -> WAIT.
- FINISH: done=1 for 1 cycle, then -> IDLE. Flags and counters hold their values until the next start.
- Timing:
  - Request sampled at edge N -> action pulse during cycle N+1.
  - SETTLE occupies cycles N+2..N+1+SETTLE_CYCLES.
  - sensor_valid returns at cycle N+2+SETTLE_CYCLES.
  - Step period = SETTLE_CYCLES+2 cycles for back-to-back requests.
- Invariants:
  - At most one action output high per cycle.
  - Never two action pulses in consecutive cycles.
  - Counters never exceed MAX_STEPS; no wrap-around is possible.
- All outputs are registered or decoded directly from registered state; no input-to-output combinational path.

Test Plan (SETTLE_CYCLES=2, MAX_STEPS=8, TRAP_TURNS=4):
- Basic step: start, then req_avancar held high -> avancar pulses every 4 cycles, 1 cycle wide. sensor_valid is low during each pulse and the 2 settle cycles. step_count reaches 3 after 3 pulses.
- Priority/conflict: in WAIT, req_remover=req_girar=req_avancar=1 for one cycle -> only remover pulses; conflict=1; remove_count=1; step_count=1. conflict stays 1 until the next start.
- Trapped: 4 consecutive req_girar -> after 4th settle, trapped=1, done pulse, IDLE, step_count=4. Repeat with girar,girar,remover,girar,girar -> trapped after step 5 (remover does not reset the streak). Insert avancar after 3 girar -> no trap.
- Timeout: alternate avancar/girar for 8 steps -> timeout=1, done pulse after the 8th settle, step_count=8. A 9th request is never issued.
- Stop handling: stop in WAIT -> FINISH next cycle, no action pulse. stop asserted during a girar pulse -> girar completes, both settle cycles occur, then done, step_count incremented. start while busy -> ignored.
- Reset mid-operation: assert reset in the ISSUE cycle -> next cycle all action outputs 0, IDLE, counters and flags 0. A new start then runs normally.
